dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer that drives frequency, phase and amplitude words into a DDS core.
// Parameters are staged in shadow registers and then applied either directly or as a stepped sweep.
module dds_sweep_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               param_wen,
    input  logic               mode,
    input  logic [DATA_W-1:0]  start_fword,
    input  logic [DATA_W-1:0]  stop_fword,
    input  logic [DATA_W-1:0]  step_fword,
    input  logic [DATA_W-1:0]  pword,
    input  logic [DATA_W-1:0]  amp,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop_en,
    input  logic               start,
    input  logic               abort,
    output logic [DATA_W-1:0]  out_fword,
    output logic [DATA_W-1:0]  out_pword,
    output logic [DATA_W-1:0]  out_amp,
    output logic               point_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Shadow copies of the parameter inputs
    logic                r_mode;
    logic [DATA_W-1:0]   r_start;
    logic [DATA_W-1:0]   r_stop;
    logic [DATA_W-1:0]   r_step;
    logic [DATA_W-1:0]   r_pword;
    logic [DATA_W-1:0]   r_amp;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_loop;

    logic [DATA_W-1:0]   r_fword;
    logic [DATA_W-1:0]   r_opword;
    logic [DATA_W-1:0]   r_oamp;
    logic                r_stb;
    logic                r_busy;
    logic                r_done;
    logic [DWELL_W-1:0]  r_cnt;

    logic [DATA_W-1:0]   w_fword_next;
    logic [DATA_W-1:0]   w_opword_next;
    logic [DATA_W-1:0]   w_oamp_next;
    logic                w_stb_next;
    logic                w_done_next;
    logic [DWELL_W-1:0]  w_cnt_next;

    logic [DWELL_W-1:0]  w_dwell_eff;
    logic                w_dwell_end;
    logic [DATA_W:0]     w_sum;
    logic                w_carry;
    logic                w_in_range;
    logic                w_degen;

    // A dwell of zero is treated as a one-cycle dwell
    assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
    assign w_dwell_end = (r_cnt == (w_dwell_eff - DWELL_W'(1)));

    // Extra bit catches wrap-around past the top of the frequency range
    assign w_sum      = {1'b0, r_fword} + {1'b0, r_step};
    assign w_carry    = w_sum[DATA_W];
    assign w_in_range = !w_carry && (w_sum[DATA_W-1:0] <= r_stop);
    assign w_degen    = (r_step == '0) || (r_start > r_stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_pword <= '0;
            r_amp   <= '0;
            r_dwell <= '0;
            r_loop  <= 1'b0;
        end else if (param_wen && (r_state == ST_IDLE)) begin
            r_mode  <= mode;
            r_start <= start_fword;
            r_stop  <= stop_fword;
            r_step  <= step_fword;
            r_pword <= pword;
            r_amp   <= amp;
            r_dwell <= dwell;
            r_loop  <= loop_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_fword_next  = r_fword;
        w_opword_next = r_opword;
        w_oamp_next   = r_oamp;
        w_stb_next    = 1'b0;
        w_done_next   = 1'b0;
        w_cnt_next    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // Abort outranks start even when nothing is running
                if (start && !abort) begin
                    w_fword_next  = r_start;
                    w_opword_next = r_pword;
                    w_oamp_next   = r_amp;
                    w_stb_next    = 1'b1;
                    w_cnt_next    = '0;
                    if (r_mode) begin
                        w_state_next = ST_SWEEP;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_dwell_end) begin
                    w_cnt_next = '0;
                    if (w_degen) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_in_range) begin
                        w_fword_next = w_sum[DATA_W-1:0];
                        w_stb_next   = 1'b1;
                    end else if (r_loop) begin
                        w_fword_next = r_start;
                        w_stb_next   = 1'b1;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + DWELL_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fword  <= '0;
            r_opword <= '0;
            r_oamp   <= '0;
            r_stb    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_fword  <= w_fword_next;
            r_opword <= w_opword_next;
            r_oamp   <= w_oamp_next;
            r_stb    <= w_stb_next;
            r_done   <= w_done_next;
            r_busy   <= (w_state_next == ST_SWEEP);
            r_cnt    <= w_cnt_next;
        end
    end

    assign out_fword = r_fword;
    assign out_pword = r_opword;
    assign out_amp   = r_oamp;
    assign point_stb = r_stb;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
